coreaxitoahbl_wstrb_gen: RTL and testbench
==========================================

Name: coreaxitoahbl_wstrb_gen

Overview:
Beat-by-beat AXI write-strobe generator. It is the inverse of the strobe-to-offset decode in the write path.
- Takes a burst descriptor: start address, AWSIZE, AWLEN, AWBURST.
- Emits, per beat, the expected WSTRB lane mask, the byte-lane address offset, and a last flag.
- Sits in the AXI write channel of CoreAXItoAHBL, feeding lane/offset info to the AHB-L write sequencer.

Parameters:
AXI_DWIDTH, 64, AXI data width; legal values 32 or 64.
AXI_STRBWIDTH, 8, strobe width = AXI_DWIDTH/8.

Ports:
ACLK  input  1  clock; all logic rising-edge.
ARESETn  input  1  asynchronous active-low reset.
cmdValid  input  1  burst descriptor valid.
cmdReady  output  1  block idle, descriptor accepted on cmdValid&cmdReady.
cmdAddr  input  12  start byte address (4 KB page offset).
cmdLen  input  8  AWLEN (beats-1).
cmdSize  input  3  AWSIZE (bytes = 1<<size).
cmdBurst  input  2  AWBURST: 00 FIXED, 01 INCR, 10 WRAP.
strbValid  output  1  beat info valid.
strbReady  input  1  consumer takes beat on strbValid&strbReady.
strbOut  output  AXI_STRBWIDTH  expected WSTRB for current beat.
strbAddrOffset  output  3  lowest enabled lane index; {1'b0,addr[1:0]} when AXI_DWIDTH=32.
strbLast  output  1  current beat is final beat.

Behaviour:
- Reset (async, ARESETn=0): state IDLE, cmdReady=0, strbValid=0, strbOut=0, strbAddrOffset=0, strbLast=0. cmdReady rises on first ACLK edge after release.
- All outputs registered.
- States:
  - IDLE: cmdReady=1, strbValid=0. On cmdValid&cmdReady: latch addr/len/size/burst, beatCnt=cmdLen, go BURST, cmdReady=0.
  - BURST: strbValid=1. Handshake with beatCnt≠0: advance address, beatCnt-1, new beat values at the same edge (no bubble). Handshake with beatCnt=0: go IDLE, strbValid=0, cmdReady=1.
- Latency: descriptor accepted at edge N → first beat valid after edge N. After a last handshake, one IDLE cycle before the next accept.
- Stall: strbReady=0 holds all outputs stable; state and address do not change.
- Lane mask, with lo = addr mod AXI_STRBWIDTH:
  - Lanes lo .. (size-aligned container end) are set.
  - First beat of an unaligned INCR/FIXED burst is partial.
  - Later INCR beats are aligned, so the full container is set.
- strbLast=1 exactly when beatCnt=0.
- Address update, with incr=1<<size:
  - INCR: addr=(addr & ~(incr-1))+incr, modulo 4096.
  - FIXED: unchanged.
  - WRAP: mask=((len+1)<<size)-1; addr=(addr & ~mask) | ((aligned(addr)+incr) & mask).
- Illegal inputs:
  - cmdSize > log2(AXI_STRBWIDTH): clamped to max.
  - Burst 11: treated as INCR.
  - WRAP with len not in {1,3,7,15}: treated as INCR.
- Simultaneous cmdValid while in BURST: ignored (cmdReady=0).
- Reset mid-burst: burst abandoned immediately, outputs to reset values.

Optional Feature:
COREAXITOAHBL_WSTRB_CHECK_EN
- Enabled: adds input WSTRBIn[AXI_STRBWIDTH-1:0] and output strbErr (1 bit, reset 0).
  - On each beat handshake, any WSTRBIn bit set outside strbOut sets strbErr.
  - strbErr is sticky until the next descriptor accept or reset.
  - Subset strobes (fewer lanes than expected) are legal.
- Disabled: neither port exists; no check logic.

Decomposition:
- Shared package (coreaxitoahbl_pkg): burst encodings FIXED/INCR/WRAP, state encoding IDLE/BURST, STRB_IDX_W = log2(AXI_STRBWIDTH).
- One sub-module: coreaxitoahbl_lane_mask. Pure combinational (addr low bits, size) → strbOut and offset. It is reused by the checker.

Test Plan:
1. 64-bit INCR, addr 0x003, size 2, len 2 → strbOut 0x08/off 3, 0xF0/off 4, 0x0F/off 0 with strbLast on beat 3; cmdReady returns 1 after one idle cycle.
2. 64-bit WRAP, addr 0x00C, size 2, len 3 → addresses 0x0C,0x00,0x04,0x08; strbOut 0xF0,0x0F,0xF0,0x0F; offsets 4,0,4,0.
3. 64-bit FIXED, addr 0x005, size 0, len 3 → four beats of 0x20/off 5; strbLast only on the 4th.
4. Backpressure: strbReady=0 for 3 cycles mid-burst → strbOut, strbAddrOffset and strbLast stable; no beat skipped or duplicated.
5. ARESETn pulsed low during beat 2 of an 8-beat INCR → outputs 0 asynchronously; cmdReady=1 one edge after release; new burst starts clean.
6. AXI_DWIDTH=32, INCR addr 0x002, size 1, len 1 → 4'b1100/off 2, then 4'b0011/off 0. With COREAXITOAHBL_WSTRB_CHECK_EN, WSTRBIn=4'b1110 on beat 1 → strbErr=1.

Source files
------------

// File: rtl/coreaxitoahbl_pkg.sv
// rtl/coreaxitoahbl_pkg.sv - burst/state encodings and descriptor normalisation helpers for the write-strobe generator
package coreaxitoahbl_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // log2 of the default 8-lane strobe; narrower builds derive their own index width
    localparam int STRB_IDX_W = 3;

    function automatic logic [2:0] clampSize(input logic [2:0] size, input logic [2:0] maxSize);
        return (size > maxSize) ? maxSize : size;
    endfunction

    // Reserved burst type and non-power-of-two wrap lengths fall back to INCR
    function automatic burst_e normBurst(input logic [1:0] burst, input logic [7:0] len);
        case (burst)
            2'b00:   return BURST_FIXED;
            2'b10:   return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                            ? BURST_WRAP : BURST_INCR;
            default: return BURST_INCR;
        endcase
    endfunction

endpackage

// File: rtl/coreaxitoahbl_wstrb_gen_if.sv
// rtl/coreaxitoahbl_wstrb_gen_if.sv - descriptor/beat bus; COREAXITOAHBL_WSTRB_CHECK_EN adds WSTRBIn/strbErr
interface coreaxitoahbl_wstrb_gen_if #(
    parameter int AXI_STRBWIDTH = 8
);
    logic                     cmdValid;
    logic                     cmdReady;
    logic [11:0]              cmdAddr;
    logic [7:0]               cmdLen;
    logic [2:0]               cmdSize;
    logic [1:0]               cmdBurst;
    logic                     strbValid;
    logic                     strbReady;
    logic [AXI_STRBWIDTH-1:0] strbOut;
    logic [2:0]               strbAddrOffset;
    logic                     strbLast;
`ifdef COREAXITOAHBL_WSTRB_CHECK_EN
    logic [AXI_STRBWIDTH-1:0] WSTRBIn;
    logic                     strbErr;

    modport master (
        output cmdValid, cmdAddr, cmdLen, cmdSize, cmdBurst, strbReady, WSTRBIn,
        input  cmdReady, strbValid, strbOut, strbAddrOffset, strbLast, strbErr
    );
    modport slave (
        input  cmdValid, cmdAddr, cmdLen, cmdSize, cmdBurst, strbReady, WSTRBIn,
        output cmdReady, strbValid, strbOut, strbAddrOffset, strbLast, strbErr
    );
`else
    modport master (
        output cmdValid, cmdAddr, cmdLen, cmdSize, cmdBurst, strbReady,
        input  cmdReady, strbValid, strbOut, strbAddrOffset, strbLast
    );
    modport slave (
        input  cmdValid, cmdAddr, cmdLen, cmdSize, cmdBurst, strbReady,
        output cmdReady, strbValid, strbOut, strbAddrOffset, strbLast
    );
`endif
endinterface

// File: rtl/coreaxitoahbl_lane_mask.sv
// rtl/coreaxitoahbl_lane_mask.sv - combinational lane mask and lowest-lane offset from address low bits and size
module coreaxitoahbl_lane_mask #(
    parameter int AXI_STRBWIDTH = 8
) (
    input  logic [$clog2(AXI_STRBWIDTH)-1:0] addrLo,
    input  logic [2:0]                       size,
    output logic [AXI_STRBWIDTH-1:0]         strb,
    output logic [2:0]                       offset
);
    localparam int IDX_W = $clog2(AXI_STRBWIDTH);

    logic [IDX_W-1:0] lastLane;

    // Enabled lanes run from the address lane up to the end of its size-aligned container
    always_comb begin
        lastLane = addrLo | IDX_W'((32'd1 << size) - 32'd1);
        for (int i = 0; i < AXI_STRBWIDTH; i++) begin
            strb[i] = (IDX_W'(i) >= addrLo) && (IDX_W'(i) <= lastLane);
        end
        offset = 3'(addrLo);
    end
endmodule

// File: rtl/coreaxitoahbl_wstrb_gen.sv
// rtl/coreaxitoahbl_wstrb_gen.sv - per-beat WSTRB/offset/last generator; COREAXITOAHBL_WSTRB_CHECK_EN adds a strobe checker
module coreaxitoahbl_wstrb_gen
    import coreaxitoahbl_pkg::*;
#(
    parameter int AXI_DWIDTH    = 64,
    parameter int AXI_STRBWIDTH = AXI_DWIDTH / 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    coreaxitoahbl_wstrb_gen_if.slave  bus
);
    localparam int         IDX_W    = $clog2(AXI_STRBWIDTH);
    localparam logic [2:0] MAX_SIZE = 3'(IDX_W);

    state_e                   state, stateN;
    logic [11:0]              addrQ, addrN, nextAddr, incr, aligned, wrapMask;
    logic [7:0]               lenQ, lenN, beatCnt, beatCntN;
    logic [2:0]               sizeQ, sizeN, maskSize, offQ, offN, laneOff;
    burst_e                   burstQ, burstN;
    logic                     cmdReadyQ, cmdReadyN, validQ, validN, lastQ, lastN;
    logic [AXI_STRBWIDTH-1:0] strbQ, strbN, laneMask;
    logic [IDX_W-1:0]         maskLo;
    logic                     accept, beatTaken;

    assign accept    = (state == IDLE) && bus.cmdValid && cmdReadyQ;
    assign beatTaken = (state == BURST) && bus.strbReady;

    always_comb begin
        incr     = 12'd1 << sizeQ;
        aligned  = addrQ & ~(incr - 12'd1);
        wrapMask = (({4'd0, lenQ} + 12'd1) << sizeQ) - 12'd1;
        case (burstQ)
            BURST_FIXED: nextAddr = addrQ;
            BURST_WRAP:  nextAddr = (addrQ & ~wrapMask) | ((aligned + incr) & wrapMask);
            default:     nextAddr = aligned + incr;
        endcase
    end

    coreaxitoahbl_lane_mask #(.AXI_STRBWIDTH(AXI_STRBWIDTH)) uLaneMask (
        .addrLo (maskLo),
        .size   (maskSize),
        .strb   (laneMask),
        .offset (laneOff)
    );

    always_comb begin
        stateN    = state;
        addrN     = addrQ;
        lenN      = lenQ;
        sizeN     = sizeQ;
        burstN    = burstQ;
        beatCntN  = beatCnt;
        cmdReadyN = cmdReadyQ;
        validN    = validQ;
        lastN     = lastQ;
        strbN     = strbQ;
        offN      = offQ;
        maskLo    = nextAddr[IDX_W-1:0];
        maskSize  = sizeQ;
        case (state)
            IDLE: begin
                cmdReadyN = 1'b1;
                maskLo    = bus.cmdAddr[IDX_W-1:0];
                maskSize  = clampSize(bus.cmdSize, MAX_SIZE);
                if (accept) begin
                    stateN    = BURST;
                    addrN     = bus.cmdAddr;
                    lenN      = bus.cmdLen;
                    sizeN     = maskSize;
                    burstN    = normBurst(bus.cmdBurst, bus.cmdLen);
                    beatCntN  = bus.cmdLen;
                    cmdReadyN = 1'b0;
                    validN    = 1'b1;
                    lastN     = (bus.cmdLen == 8'd0);
                    strbN     = laneMask;
                    offN      = laneOff;
                end
            end
            BURST: begin
                // Next beat is loaded on the same edge that retires the current one
                if (beatTaken) begin
                    if (beatCnt != 8'd0) begin
                        addrN    = nextAddr;
                        beatCntN = beatCnt - 8'd1;
                        lastN    = (beatCnt == 8'd1);
                        strbN    = laneMask;
                        offN     = laneOff;
                    end else begin
                        stateN    = IDLE;
                        validN    = 1'b0;
                        cmdReadyN = 1'b1;
                        lastN     = 1'b0;
                        strbN     = '0;
                        offN      = '0;
                    end
                end
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            addrQ     <= '0;
            lenQ      <= '0;
            sizeQ     <= '0;
            burstQ    <= BURST_FIXED;
            beatCnt   <= '0;
            cmdReadyQ <= 1'b0;
            validQ    <= 1'b0;
            lastQ     <= 1'b0;
            strbQ     <= '0;
            offQ      <= '0;
        end else begin
            state     <= stateN;
            addrQ     <= addrN;
            lenQ      <= lenN;
            sizeQ     <= sizeN;
            burstQ    <= burstN;
            beatCnt   <= beatCntN;
            cmdReadyQ <= cmdReadyN;
            validQ    <= validN;
            lastQ     <= lastN;
            strbQ     <= strbN;
            offQ      <= offN;
        end
    end

    assign bus.cmdReady       = cmdReadyQ;
    assign bus.strbValid      = validQ;
    assign bus.strbOut        = strbQ;
    assign bus.strbAddrOffset = offQ;
    assign bus.strbLast       = lastQ;

`ifdef COREAXITOAHBL_WSTRB_CHECK_EN
    logic strbErrQ;

    // Fewer lanes than expected is legal; only lanes outside the expected mask flag an error
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            strbErrQ <= 1'b0;
        end else if (accept) begin
            strbErrQ <= 1'b0;
        end else if (beatTaken && |(bus.WSTRBIn & ~strbQ)) begin
            strbErrQ <= 1'b1;
        end
    end

    assign bus.strbErr = strbErrQ;
`endif
endmodule

// File: tb/tb_coreaxitoahbl_wstrb_gen.sv
// tb/tb_coreaxitoahbl_wstrb_gen.sv - directed self-checking bench for the write-strobe generator
module tb_coreaxitoahbl_wstrb_gen;
    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    int   nCmp    = 0;
    int   nErr    = 0;

    always #5 ACLK = ~ACLK;

    coreaxitoahbl_wstrb_gen_if #(.AXI_STRBWIDTH(8)) b64 ();
    coreaxitoahbl_wstrb_gen_if #(.AXI_STRBWIDTH(4)) b32 ();

    coreaxitoahbl_wstrb_gen #(.AXI_DWIDTH(64)) dut64 (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (b64)
    );

    coreaxitoahbl_wstrb_gen #(.AXI_DWIDTH(32)) dut32 (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (b32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send64(input logic [11:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        while (b64.cmdReady !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("send64.cmdReady", 32'(b64.cmdReady), 32'd1);
        b64.cmdAddr  = addr;
        b64.cmdLen   = len;
        b64.cmdSize  = size;
        b64.cmdBurst = burst;
        b64.cmdValid = 1'b1;
        @(negedge ACLK);
        b64.cmdValid = 1'b0;
    endtask

    task automatic beat64(input string tag, input logic [7:0] expStrb,
                          input logic [2:0] expOff, input logic expLast);
        chk({tag, ".valid"}, 32'(b64.strbValid), 32'd1);
        chk({tag, ".strb"}, 32'(b64.strbOut), 32'(expStrb));
        chk({tag, ".off"}, 32'(b64.strbAddrOffset), 32'(expOff));
        chk({tag, ".last"}, 32'(b64.strbLast), 32'(expLast));
        @(negedge ACLK);
    endtask

    initial begin
        b64.cmdValid = 1'b0; b64.cmdAddr = '0; b64.cmdLen = '0; b64.cmdSize = '0;
        b64.cmdBurst = '0;   b64.strbReady = 1'b1;
        b32.cmdValid = 1'b0; b32.cmdAddr = '0; b32.cmdLen = '0; b32.cmdSize = '0;
        b32.cmdBurst = '0;   b32.strbReady = 1'b1;
`ifdef COREAXITOAHBL_WSTRB_CHECK_EN
        b64.WSTRBIn = '0;
        b32.WSTRBIn = '0;
`endif
        repeat (2) @(negedge ACLK);

        chk("rst.cmdReady", 32'(b64.cmdReady), 32'd0);
        chk("rst.valid", 32'(b64.strbValid), 32'd0);
        chk("rst.strb", 32'(b64.strbOut), 32'd0);
        chk("rst.off", 32'(b64.strbAddrOffset), 32'd0);
        chk("rst.last", 32'(b64.strbLast), 32'd0);
        ARESETn = 1'b1;
        chk("rst.readyBeforeEdge", 32'(b64.cmdReady), 32'd0);
        @(negedge ACLK);
        chk("rst.readyAfterEdge", 32'(b64.cmdReady), 32'd1);

        // INCR unaligned start
        send64(12'h003, 8'd2, 3'd2, 2'b01);
        chk("t1.readyInBurst", 32'(b64.cmdReady), 32'd0);
        beat64("t1b1", 8'h08, 3'd3, 1'b0);
        beat64("t1b2", 8'hF0, 3'd4, 1'b0);
        beat64("t1b3", 8'h0F, 3'd0, 1'b1);
        chk("t1.idleValid", 32'(b64.strbValid), 32'd0);
        chk("t1.idleReady", 32'(b64.cmdReady), 32'd1);

        // WRAP 4x4 bytes starting at 0x0C
        send64(12'h00C, 8'd3, 3'd2, 2'b10);
        beat64("t2b1", 8'hF0, 3'd4, 1'b0);
        beat64("t2b2", 8'h0F, 3'd0, 1'b0);
        beat64("t2b3", 8'hF0, 3'd4, 1'b0);
        beat64("t2b4", 8'h0F, 3'd0, 1'b1);

        // FIXED, with a stray descriptor offered mid-burst
        send64(12'h005, 8'd3, 3'd0, 2'b00);
        beat64("t3b1", 8'h20, 3'd5, 1'b0);
        b64.cmdAddr = 12'h000; b64.cmdBurst = 2'b01; b64.cmdValid = 1'b1;
        chk("t3.readyIgnored", 32'(b64.cmdReady), 32'd0);
        beat64("t3b2", 8'h20, 3'd5, 1'b0);
        beat64("t3b3", 8'h20, 3'd5, 1'b0);
        b64.cmdValid = 1'b0;
        beat64("t3b4", 8'h20, 3'd5, 1'b1);

        // Backpressure on beat 2
        send64(12'h000, 8'd3, 3'd0, 2'b01);
        beat64("t4b1", 8'h01, 3'd0, 1'b0);
        b64.strbReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4.stallValid", 32'(b64.strbValid), 32'd1);
            chk("t4.stallStrb", 32'(b64.strbOut), 32'h02);
            chk("t4.stallOff", 32'(b64.strbAddrOffset), 32'd1);
            chk("t4.stallLast", 32'(b64.strbLast), 32'd0);
            @(negedge ACLK);
        end
        b64.strbReady = 1'b1;
        beat64("t4b2", 8'h02, 3'd1, 1'b0);
        beat64("t4b3", 8'h04, 3'd2, 1'b0);
        beat64("t4b4", 8'h08, 3'd3, 1'b1);

        // Illegal inputs: oversize clamp, reserved burst, bad wrap length
        send64(12'h001, 8'd1, 3'd7, 2'b01);
        beat64("ilSz.b1", 8'hFE, 3'd1, 1'b0);
        beat64("ilSz.b2", 8'hFF, 3'd0, 1'b1);
        send64(12'h006, 8'd1, 3'd1, 2'b11);
        beat64("ilBu.b1", 8'hC0, 3'd6, 1'b0);
        beat64("ilBu.b2", 8'h03, 3'd0, 1'b1);
        send64(12'h00C, 8'd2, 3'd2, 2'b10);
        beat64("ilWr.b1", 8'hF0, 3'd4, 1'b0);
        beat64("ilWr.b2", 8'h0F, 3'd0, 1'b0);
        beat64("ilWr.b3", 8'hF0, 3'd4, 1'b1);

        // Reset during beat 2 of an 8-beat INCR
        send64(12'h000, 8'd7, 3'd0, 2'b01);
        beat64("t5b1", 8'h01, 3'd0, 1'b0);
        chk("t5.b2strb", 32'(b64.strbOut), 32'h02);
        #2 ARESETn = 1'b0;
        #1;
        chk("t5.rstValid", 32'(b64.strbValid), 32'd0);
        chk("t5.rstStrb", 32'(b64.strbOut), 32'd0);
        chk("t5.rstOff", 32'(b64.strbAddrOffset), 32'd0);
        chk("t5.rstLast", 32'(b64.strbLast), 32'd0);
        chk("t5.rstReady", 32'(b64.cmdReady), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("t5.readyAfter", 32'(b64.cmdReady), 32'd1);
        chk("t5.validAfter", 32'(b64.strbValid), 32'd0);
        send64(12'h010, 8'd1, 3'd1, 2'b01);
        beat64("t5n.b1", 8'h03, 3'd0, 1'b0);
        beat64("t5n.b2", 8'h0C, 3'd2, 1'b1);

        // 32-bit data path
        chk("t6.ready", 32'(b32.cmdReady), 32'd1);
        b32.cmdAddr = 12'h002; b32.cmdLen = 8'd1; b32.cmdSize = 3'd1; b32.cmdBurst = 2'b01;
        b32.cmdValid = 1'b1;
`ifdef COREAXITOAHBL_WSTRB_CHECK_EN
        b32.WSTRBIn = 4'b1110;
`endif
        @(negedge ACLK);
        b32.cmdValid = 1'b0;
        chk("t6b1.valid", 32'(b32.strbValid), 32'd1);
        chk("t6b1.strb", 32'(b32.strbOut), 32'hC);
        chk("t6b1.off", 32'(b32.strbAddrOffset), 32'd2);
        chk("t6b1.last", 32'(b32.strbLast), 32'd0);
`ifdef COREAXITOAHBL_WSTRB_CHECK_EN
        chk("t6.errBefore", 32'(b32.strbErr), 32'd0);
`endif
        @(negedge ACLK);
`ifdef COREAXITOAHBL_WSTRB_CHECK_EN
        chk("t6.errSet", 32'(b32.strbErr), 32'd1);
        b32.WSTRBIn = 4'b0001;
`endif
        chk("t6b2.strb", 32'(b32.strbOut), 32'h3);
        chk("t6b2.off", 32'(b32.strbAddrOffset), 32'd0);
        chk("t6b2.last", 32'(b32.strbLast), 32'd1);
        @(negedge ACLK);
        chk("t6.idleValid", 32'(b32.strbValid), 32'd0);
`ifdef COREAXITOAHBL_WSTRB_CHECK_EN
        chk("t6.errSticky", 32'(b32.strbErr), 32'd1);
        chk("t6.err64Clean", 32'(b64.strbErr), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
